sync_filter_bank: RTL
=====================

# sync_filter_bank

Multi-channel input conditioning bank: brings WIDTH asynchronous single-bit signals (buttons, switches, external strobes) into the `clk` domain through a STAGES-deep flop chain per channel. It then applies a per-channel stability filter and emits registered level outputs plus single-cycle rise/fall event pulses. It is the parametrised successor of the single-flop crossing buffer and sits between top-level pins and control logic.

## Interface
- WIDTH, 8, number of independent channels (≥1)
- STAGES, 2, synchroniser flops per channel (≥2)
- FILTER_CYCLES, 4, consecutive cycles a new level must persist after synchronisation before acceptance (≥1; 1 = no filtering)
- RESET_VAL, {WIDTH{1'b0}}, reset level of sync chain and `data_out`, per channel
- clk  in  1  sole clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- async_in  in  WIDTH  raw asynchronous inputs, bit i = channel i
- data_out  out  WIDTH  filtered, synchronised level
- rise  out  WIDTH  1-cycle pulse, channel accepted 0→1
- fall  out  WIDTH  1-cycle pulse, channel accepted 1→0
- changed  out  1  registered OR of (rise | fall)

## Operation
- Per channel: sync chain s[0..STAGES-1]; s[0] <= async_in[i], s[k] <= s[k-1]; sync_q = s[STAGES-1].
- Filter counter cnt, width $clog2(FILTER_CYCLES+1).
- Each cycle: if sync_q == data_out → cnt <= 0. Else if cnt == FILTER_CYCLES-1 → data_out <= sync_q, cnt <= 0, rise/fall asserted per direction. Else cnt <= cnt+1.
- Any cycle with sync_q equal to data_out clears cnt: glitches shorter than FILTER_CYCLES cycles (post-sync) never reach `data_out`.
- rise/fall are registered, high for exactly the one cycle in which the new `data_out` value first appears; never both high on one channel.
- Channels fully independent; simultaneous acceptance on several channels gives simultaneous pulses and one `changed` cycle.
- `changed` asserts in the same cycle as the pulses (computed from next-state values, registered).
- Counter never exceeds FILTER_CYCLES-1; no wrap.

## Timing
- Reset (rst high at an edge): all s[k] and data_out <= RESET_VAL; cnt <= 0; rise, fall, changed <= 0. Held while rst high.
- First cycle after reset releases: no pulses, even if async_in ≠ RESET_VAL; a real difference is filtered normally and produces one pulse.
- Reset mid-count discards the in-flight count; no pulse is produced for it.
- Latency: new level stable before edge E1 (first capture), `data_out`/pulse update at edge E(STAGES+FILTER_CYCLES). Defaults: 6 edges.
- Minimum accepted pulse width on async_in: FILTER_CYCLES cycles. Minimum spacing between accepted edges on one channel: FILTER_CYCLES cycles.
- Input toggling back before acceptance: cnt clears; no output change, no pulse.

## Structure
- Shared package `sync_pkg`: default parameter constants (SYNC_STAGES_DEF = 2, FILTER_CYCLES_DEF = 4) and a counter-width function.
- Sub-module `sync_filter_channel` (one channel: chain, counter, pulse regs), parameters STAGES, FILTER_CYCLES, RESET_VAL (1 bit); top instantiates WIDTH copies via generate and ORs pulses into `changed`.
- Synchroniser flops marked with the team's ASYNC_REG attribute; no logic between chain stages.

## Test plan
- Reset: async_in = 8'hFF, rst high 3 cycles then low -> data_out = 8'h00 during reset, rise[7:0] pulses exactly once at edge 6 after release; no fall.
- Clean edge, ch0: async_in[0] 0→1 held -> data_out[0] = 1 at edge 6, rise[0] and changed high 1 cycle, then low.
- Glitch rejection: async_in[3] high for 3 cycles (FILTER_CYCLES = 4) -> data_out[3] stays 0, no rise/fall/changed.
- Simultaneous: channels 1 and 5 change same cycle (1: 0→1, 5: 1→0 from settled 1) -> rise[1] and fall[5] same cycle, changed single 1-cycle pulse.
- Reset mid-count: async_in[2] rises, rst asserted 4 edges later for 1 cycle -> data_out[2] = 0, no pulse from aborted count; re-filtered rise[2] 6 edges after release.
- Parameter sweep: STAGES=3, FILTER_CYCLES=1, WIDTH=1 -> latency 4 edges, every 1-cycle post-sync pulse propagates.

Source files
------------

// File: rtl/sync_pkg.sv
// Shared constants and helpers for the input-conditioning (synchroniser + stability filter) blocks.
package sync_pkg;

  localparam int SYNC_STAGES_DEF   = 2;
  localparam int FILTER_CYCLES_DEF = 4;

  // Counter wide enough to hold 0..filterCycles; never narrower than one bit.
  function automatic int cntWidth(input int filterCycles);
    return (filterCycles < 1) ? 1 : $clog2(filterCycles + 1);
  endfunction

endpackage

// File: rtl/sync_filter_channel.sv
// One conditioning channel: flop-chain synchroniser, persistence filter and registered rise/fall pulses.
module sync_filter_channel
  import sync_pkg::*;
#(
  parameter int   STAGES        = SYNC_STAGES_DEF,
  parameter int   FILTER_CYCLES = FILTER_CYCLES_DEF,
  parameter logic RESET_VAL     = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_async,
  output logic o_data,
  output logic o_rise,
  output logic o_fall,
  output logic o_eventNext
);

  localparam int            CW       = cntWidth(FILTER_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_CYCLES - 1);

  (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] r_syncChain;

  logic [CW-1:0] r_cnt;
  logic          r_data;
  logic          r_rise;
  logic          r_fall;
  logic          w_syncQ;
  logic          w_differs;
  logic          w_accept;

  assign w_syncQ   = r_syncChain[STAGES-1];
  assign w_differs = (w_syncQ != r_data);
  assign w_accept  = w_differs && (r_cnt == CNT_LAST);

  // Any cycle where the synchronised level agrees with the output restarts the persistence count.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_syncChain <= {STAGES{RESET_VAL}};
      r_data      <= RESET_VAL;
      r_cnt       <= '0;
      r_rise      <= 1'b0;
      r_fall      <= 1'b0;
    end else begin
      r_syncChain <= {r_syncChain[STAGES-2:0], i_async};
      r_rise      <= w_accept && w_syncQ;
      r_fall      <= w_accept && !w_syncQ;
      if (!w_differs) begin
        r_cnt <= '0;
      end else if (w_accept) begin
        r_data <= w_syncQ;
        r_cnt  <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_data      = r_data;
  assign o_rise      = r_rise;
  assign o_fall      = r_fall;
  assign o_eventNext = w_accept && !i_rst;

endmodule

// File: rtl/sync_filter_bank.sv
// Multi-channel pin conditioning bank: WIDTH independent filtered channels plus a shared "changed" strobe.
module sync_filter_bank
  import sync_pkg::*;
#(
  parameter int               WIDTH         = 8,
  parameter int               STAGES        = SYNC_STAGES_DEF,
  parameter int               FILTER_CYCLES = FILTER_CYCLES_DEF,
  parameter logic [WIDTH-1:0] RESET_VAL     = {WIDTH{1'b0}}
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_async_in,
  output logic [WIDTH-1:0] o_data_out,
  output logic [WIDTH-1:0] o_rise,
  output logic [WIDTH-1:0] o_fall,
  output logic             o_changed
);

  logic [WIDTH-1:0] w_eventNext;
  logic             r_changed;

  for (genvar g = 0; g < WIDTH; g++) begin : g_channel
    sync_filter_channel #(
      .STAGES       (STAGES),
      .FILTER_CYCLES(FILTER_CYCLES),
      .RESET_VAL    (RESET_VAL[g])
    ) u_channel (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_async    (i_async_in[g]),
      .o_data     (o_data_out[g]),
      .o_rise     (o_rise[g]),
      .o_fall     (o_fall[g]),
      .o_eventNext(w_eventNext[g])
    );
  end

  // Built from the channels' next-cycle acceptances so it lines up with the registered pulses.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_changed <= 1'b0;
    end else begin
      r_changed <= |w_eventNext;
    end
  end

  assign o_changed = r_changed;

endmodule
